capture_arbiter: RTL and testbench

//  Round-robin arbiter and sequencer for the two-stage capture register bank
//  (5-bit data register plus two 1-bit flag registers, then a second-stage commit).

---
 rtl/capture_arbiter.sv | 136 +++++++++++++
 tb/tb_capture_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/capture_arbiter.sv
// ============================================================================
// Module   : capture_arbiter
// Brief    : Round-robin arbiter/sequencer for a two-stage capture register bank.
// Revision : 1.0
// ============================================================================
`default_nettype none

module capture_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [1:0]       valido,
    input  logic [1:0]       terminar,
    output logic [1:0]       gnt,
    output logic             sel,
    output logic             pasar1,
    output logic             pasar2,
    output logic             pasar3,
    output logic             listo,
    output logic             ocupado,
    output logic             err_to,
    output logic [CNT_W-1:0] n_commit
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_GRANT     = 3'd1;
    localparam logic [2:0] c_CAP_D     = 3'd2;
    localparam logic [2:0] c_CAP_F0    = 3'd3;
    localparam logic [2:0] c_CAP_F1    = 3'd4;
    localparam logic [2:0] c_WAIT_TERM = 3'd5;
    localparam logic [2:0] c_COMMIT    = 3'd6;
    localparam logic [2:0] c_ABORT     = 3'd7;

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    logic             sel_q, sel_d;
    logic             last_q, last_d;
    logic [1:0]       gnt_q, gnt_d;
    logic [TO_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic w_req_own;
    logic w_to_last;

    assign w_req_own = req[sel_q];
    assign w_to_last = (timer_q == c_TO_LAST);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        case (state_q)
            c_IDLE: begin
                if (req != 2'b00) begin
                    // Both requesting: alternate away from the last owner.
                    sel_d   = (req == 2'b11) ? ~last_q : req[1];
                    gnt_d   = sel_d ? 2'b10 : 2'b01;
                    timer_d = '0;
                    state_d = c_GRANT;
                end
            end
            c_GRANT: begin
                if (!w_req_own)           state_d = c_ABORT;
                else if (valido[sel_q])   state_d = c_CAP_D;
                else if (w_to_last)       state_d = c_ABORT;
                else                      timer_d = timer_q + 1'b1;
            end
            c_CAP_D:  state_d = c_CAP_F0;
            c_CAP_F0: state_d = c_CAP_F1;
            c_CAP_F1: begin
                timer_d = '0;
                state_d = c_WAIT_TERM;
            end
            c_WAIT_TERM: begin
                if (!w_req_own)           state_d = c_ABORT;
                else if (terminar[sel_q]) state_d = c_COMMIT;
                else if (w_to_last)       state_d = c_ABORT;
                else                      timer_d = timer_q + 1'b1;
            end
            c_COMMIT: begin
                cnt_d   = cnt_q + 1'b1;
                last_d  = sel_q;
                gnt_d   = 2'b00;
                state_d = c_IDLE;
            end
            c_ABORT: begin
                last_d  = sel_q;
                gnt_d   = 2'b00;
                state_d = c_IDLE;
            end
            default: begin
                gnt_d   = 2'b00;
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_IDLE;
            sel_q   <= 1'b0;
            last_q  <= 1'b1;
            gnt_q   <= 2'b00;
            timer_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt      = gnt_q;
    assign sel      = sel_q;
    assign pasar1   = (state_q == c_CAP_D);
    assign pasar2   = (state_q == c_CAP_F0);
    assign pasar3   = (state_q == c_CAP_F1);
    assign listo    = (state_q == c_COMMIT);
    assign err_to   = (state_q == c_ABORT);
    assign ocupado  = (state_q != c_IDLE);
    assign n_commit = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_capture_arbiter.sv
// ============================================================================
// Module   : tb_capture_arbiter
// Brief    : Self-checking bench for capture_arbiter (vectors, sequences, random).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_capture_arbiter;

    localparam int TIMEOUT = 4;
    localparam int TO_W    = 3;
    localparam int CNT_W   = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req, valido, terminar;
    logic [1:0]       gnt;
    logic             sel, pasar1, pasar2, pasar3, listo, ocupado, err_to;
    logic [CNT_W-1:0] n_commit;

    capture_arbiter #(.TIMEOUT(TIMEOUT), .TO_W(TO_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .req(req), .valido(valido), .terminar(terminar),
        .gnt(gnt), .sel(sel), .pasar1(pasar1), .pasar2(pasar2), .pasar3(pasar3),
        .listo(listo), .ocupado(ocupado), .err_to(err_to), .n_commit(n_commit)
    );

    always #5 clk = ~clk;

    // Observed bundle: {gnt, sel, pasar3, pasar2, pasar1, listo, ocupado, err_to, n_commit}
    logic [11:0] w_obs;
    assign w_obs = {gnt, sel, pasar3, pasar2, pasar1, listo, ocupado, err_to, n_commit};

    int checks   = 0;
    int failures = 0;

    // Reference model: transaction phase of the current owner.
    // 0 idle, 1 awaiting data, 2..4 capture pulse k-1, 5 awaiting done, 6 committing, 7 aborting
    int m_phase, m_age, m_n;
    bit m_sel, m_last;

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_n = 0; m_sel = 1'b0; m_last = 1'b1;
    endtask

    task automatic model_step(input logic [1:0] r, input logic [1:0] v, input logic [1:0] t);
        bit ev;
        case (m_phase)
            0: if (r != 2'b00) begin
                m_sel   = (r == 2'b11) ? !m_last : (r == 2'b10);
                m_phase = 1;
                m_age   = 0;
            end
            1, 5: begin
                ev = (m_phase == 1) ? v[m_sel] : t[m_sel];
                if (!r[m_sel])                m_phase = 7;
                else if (ev)                  m_phase = (m_phase == 1) ? 2 : 6;
                else if (m_age == TIMEOUT-1)  m_phase = 7;
                else                          m_age++;
            end
            2, 3: m_phase++;
            4: begin m_phase = 5; m_age = 0; end
            6: begin m_n = (m_n + 1) % (1 << CNT_W); m_last = m_sel; m_phase = 0; end
            default: begin m_last = m_sel; m_phase = 0; end
        endcase
    endtask

    function automatic logic [11:0] model_out();
        logic [1:0] g;
        logic [2:0] p;
        g = (m_phase != 0) ? (m_sel ? 2'b10 : 2'b01) : 2'b00;
        p = (m_phase == 2) ? 3'b001 : (m_phase == 3) ? 3'b010 : (m_phase == 4) ? 3'b100 : 3'b000;
        return {g, m_sel, p, (m_phase == 6), (m_phase != 0), (m_phase == 7), CNT_W'(m_n)};
    endfunction

    function automatic logic [11:0] mk(logic [1:0] g, logic s, logic [2:0] p, logic l,
                                       logic o, logic e, logic [1:0] n);
        return {g, s, p, l, o, e, n};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, step model at posedge, compare at next negedge.
    task automatic cyc(input logic [1:0] r, input logic [1:0] v, input logic [1:0] t);
        req = r; valido = v; terminar = t;
        @(posedge clk);
        model_step(r, v, t);
        @(negedge clk);
        chk("model", 32'(w_obs), 32'(model_out()));
        chk("exclusive", 32'($onehot0({pasar1, pasar2, pasar3, listo}) && !(listo && err_to)), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        reset = 1'b1;
    endtask

    // Full transaction for requester 'who' with req held at r.
    task automatic txn(input logic [1:0] r, input int who, input int exp_n);
        logic [1:0] own, oth;
        own = (who == 1) ? 2'b10 : 2'b01;
        oth = ~own;
        cyc(r, 2'b00, 2'b00);  chk("txn_gnt", 32'(gnt), 32'(own));
        cyc(r, oth, 2'b00);    chk("txn_other_valid", 32'(pasar1), 32'd0);
        cyc(r, own, 2'b00);    chk("txn_pasar1", 32'(pasar1), 32'd1);
        cyc(r, 2'b00, 2'b00);  chk("txn_pasar2", 32'(pasar2), 32'd1);
        cyc(r, 2'b00, 2'b00);  chk("txn_pasar3", 32'(pasar3), 32'd1);
        cyc(r, 2'b00, 2'b00);
        cyc(r, 2'b00, own);    chk("txn_listo", 32'(listo), 32'd1);
        cyc(r, 2'b00, 2'b00);  chk("txn_ncommit", 32'(n_commit), 32'(exp_n));
    endtask

    typedef struct {
        logic [1:0]  r, v, t;
        logic [11:0] exp;
    } vec_t;

    vec_t tab[9];
    logic [1:0] rq;

    initial begin
        tab[0] = '{2'b01, 2'b00, 2'b00, mk(2'b01, 0, 3'b000, 0, 1, 0, 2'd0)};
        tab[1] = '{2'b01, 2'b00, 2'b00, mk(2'b01, 0, 3'b000, 0, 1, 0, 2'd0)};
        tab[2] = '{2'b01, 2'b01, 2'b00, mk(2'b01, 0, 3'b001, 0, 1, 0, 2'd0)};
        tab[3] = '{2'b01, 2'b00, 2'b00, mk(2'b01, 0, 3'b010, 0, 1, 0, 2'd0)};
        tab[4] = '{2'b01, 2'b00, 2'b00, mk(2'b01, 0, 3'b100, 0, 1, 0, 2'd0)};
        tab[5] = '{2'b01, 2'b00, 2'b00, mk(2'b01, 0, 3'b000, 0, 1, 0, 2'd0)};
        tab[6] = '{2'b01, 2'b00, 2'b00, mk(2'b01, 0, 3'b000, 0, 1, 0, 2'd0)};
        tab[7] = '{2'b01, 2'b00, 2'b01, mk(2'b01, 0, 3'b000, 1, 1, 0, 2'd0)};
        tab[8] = '{2'b00, 2'b00, 2'b00, mk(2'b00, 0, 3'b000, 0, 0, 0, 2'd1)};

        reset = 1'b0; req = 2'b00; valido = 2'b00; terminar = 2'b00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", 32'(w_obs), 32'd0);
        reset = 1'b1;

        // T1: single clean transaction from the vector table
        foreach (tab[i]) begin
            cyc(tab[i].r, tab[i].v, tab[i].t);
            chk($sformatf("vec%0d", i), 32'(w_obs), 32'(tab[i].exp));
        end

        // T2: req=11 held, grants alternate 0,1,0
        do_reset();
        txn(2'b11, 0, 1);
        txn(2'b11, 1, 2);
        txn(2'b11, 0, 3);

        // T3: timeout in GRANT after exactly TIMEOUT cycles
        cyc(2'b10, 2'b00, 2'b00);  chk("t3_gnt", 32'(gnt), 32'h2);
        for (int k = 0; k < TIMEOUT-1; k++) begin
            cyc(2'b10, 2'b00, 2'b00);
            chk("t3_no_err_yet", 32'(err_to), 32'd0);
        end
        cyc(2'b10, 2'b00, 2'b00);
        chk("t3_err", 32'(err_to), 32'd1);
        chk("t3_no_listo", 32'(listo), 32'd0);
        cyc(2'b11, 2'b00, 2'b00);  chk("t3_idle", 32'(gnt), 32'h0);
        cyc(2'b11, 2'b00, 2'b00);  chk("t3_regrant0", 32'(gnt), 32'h1);

        // T4: withdrawal together with terminar -> abort, no commit
        cyc(2'b11, 2'b01, 2'b00);
        cyc(2'b11, 2'b00, 2'b00);
        cyc(2'b11, 2'b00, 2'b00);
        cyc(2'b11, 2'b00, 2'b00);
        cyc(2'b10, 2'b00, 2'b01);
        chk("t4_err", 32'(err_to), 32'd1);
        chk("t4_no_listo", 32'(listo), 32'd0);
        cyc(2'b00, 2'b00, 2'b00);  chk("t4_ncommit", 32'(n_commit), 32'd3);

        // T5: asynchronous reset during CAP_F0
        cyc(2'b01, 2'b00, 2'b00);
        cyc(2'b01, 2'b01, 2'b00);
        cyc(2'b01, 2'b00, 2'b00);  chk("t5_in_f0", 32'(pasar2), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_async_clear", 32'(w_obs), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("t5_held_clear", 32'(w_obs), 32'd0);
        reset = 1'b1;
        txn(2'b01, 0, 1);

        // T6: counter wrap with CNT_W=2: 2,3,0,1
        txn(2'b01, 0, 2);
        txn(2'b01, 0, 3);
        txn(2'b01, 0, 0);
        txn(2'b01, 0, 1);

        // Randomized traffic against the model
        do_reset();
        rq = 2'b00;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(15) == 0) rq[0] = ~rq[0];
            if ($urandom_range(15) == 0) rq[1] = ~rq[1];
            if ($urandom_range(599) == 0) do_reset();
            cyc(rq,
                {($urandom_range(3) == 0), ($urandom_range(3) == 0)},
                {($urandom_range(3) == 0), ($urandom_range(3) == 0)});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
